// File: rtl/alu_integer_pipe.sv
// Multi-lane signed integer ALU behind a valid/ready handshake.
// Add, sub and pass finish in one cycle; multiply runs an iterative shift-add per lane.
module alu_integer_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] A,
    input  logic [LANES*DATA_WIDTH-1:0] B,
    input  logic [1:0]                  opcode,
    input  logic                        sat,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] Out,
    output logic [LANES-1:0]            C,
    output logic [LANES-1:0]            N,
    output logic [LANES-1:0]            V,
    output logic [LANES-1:0]            Z
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state, state_next;
    logic               accept;
    logic [CW-1:0]      iter_cnt;
    logic [LANES*W-1:0] a_q, b_q;
    logic [1:0]         op_q;
    logic               sat_q;
    logic [2*W-1:0]     acc    [LANES];
    logic [2*W-1:0]     mcand  [LANES];
    logic [W-1:0]       mplier [LANES];
    logic [LANES-1:0]   prod_neg;
    logic [LANES*W-1:0] res;
    logic [LANES-1:0]   res_c, res_n, res_v, res_z;

    // The most negative value maps to 2^(W-1), which still fits unsigned in W bits.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] x);
        return x[W-1] ? (~x + W'(1)) : x;
    endfunction

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (opcode == OP_MUL) ? MUL : DONE;
                end
            end
            MUL: begin
                if (iter_cnt == CW'(W - 1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            sat_q    <= 1'b0;
            iter_cnt <= '0;
        end else if (accept) begin
            a_q      <= A;
            b_q      <= B;
            op_q     <= opcode;
            sat_q    <= sat;
            iter_cnt <= '0;
        end else if (state == MUL) begin
            iter_cnt <= iter_cnt + CW'(1);
        end
    end

    // All lanes consume one multiplier bit per cycle in lockstep; sign is reapplied at the end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_neg <= '0;
            for (int i = 0; i < LANES; i++) begin
                acc[i]    <= '0;
                mcand[i]  <= '0;
                mplier[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                acc[i]      <= '0;
                mcand[i]    <= {{W{1'b0}}, magnitude(A[i*W +: W])};
                mplier[i]   <= magnitude(B[i*W +: W]);
                prod_neg[i] <= A[i*W + W - 1] ^ B[i*W + W - 1];
            end
        end else if (state == MUL) begin
            for (int i = 0; i < LANES; i++) begin
                if (mplier[i][0]) begin
                    acc[i] <= acc[i] + mcand[i];
                end
                mcand[i]  <= mcand[i] << 1;
                mplier[i] <= mplier[i] >> 1;
            end
        end
    end

    always_comb begin
        res   = '0;
        res_c = '0;
        res_n = '0;
        res_v = '0;
        res_z = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [W-1:0]   la, lb, wrapped, final_val;
            logic [W:0]     sum_ext, diff_ext;
            logic [2*W-1:0] product;
            logic           ovf, neg_exact, carry;
            la        = a_q[i*W +: W];
            lb        = b_q[i*W +: W];
            sum_ext   = {1'b0, la} + {1'b0, lb};
            diff_ext  = {1'b0, la} + {1'b0, ~lb} + (W + 1)'(1);
            product   = prod_neg[i] ? (~acc[i] + (2 * W)'(1)) : acc[i];
            wrapped   = la;
            carry     = 1'b0;
            ovf       = 1'b0;
            neg_exact = la[W-1];
            // On add/sub overflow the true result always carries the sign of A.
            unique case (op_q)
                OP_ADD: begin
                    wrapped = sum_ext[W-1:0];
                    carry   = sum_ext[W];
                    ovf     = (la[W-1] == lb[W-1]) && (wrapped[W-1] != la[W-1]);
                end
                OP_SUB: begin
                    wrapped = diff_ext[W-1:0];
                    carry   = diff_ext[W];
                    ovf     = (la[W-1] != lb[W-1]) && (wrapped[W-1] != la[W-1]);
                end
                OP_MUL: begin
                    wrapped   = product[W-1:0];
                    ovf       = !((&product[2*W-1:W-1]) || !(|product[2*W-1:W-1]));
                    neg_exact = product[2*W-1];
                end
                default: begin
                    wrapped = la;
                end
            endcase
            final_val = (sat_q && ovf) ?
                        (neg_exact ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) :
                        wrapped;
            res[i*W +: W] = final_val;
            res_c[i]      = carry;
            res_v[i]      = ovf;
            res_n[i]      = final_val[W-1];
            res_z[i]      = (final_val == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            Out       <= '0;
            C         <= '0;
            N         <= '0;
            V         <= '0;
            Z         <= '0;
        end else if (state == DONE) begin
            out_valid <= 1'b1;
            Out       <= res;
            C         <= res_c;
            N         <= res_n;
            V         <= res_v;
            Z         <= res_z;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/alu_integer_pipe.md
ALU_INTEGER_PIPE -- requirements
Module: alu_integer_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 8, lane width in bits (legal 4..32).
REQ-002 Parameter LANES, default 2, number of independent SIMD lanes (legal 1..8).
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  operation request valid.
REQ-006 Port in_ready  output  1  block can accept a request this cycle.
REQ-007 Port A  input  LANES*DATA_WIDTH  packed signed operands; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port B  input  LANES*DATA_WIDTH  packed signed operands, same packing.
REQ-009 Port opcode  input  2  00 add, 01 sub, 10 mul, 11 pass A.
REQ-010 Port sat  input  1  1 = saturate on overflow, 0 = wrap.
REQ-011 Port out_valid  output  1  result registered and valid.
REQ-012 Port out_ready  input  1  consumer accepts result.
REQ-013 Port Out  output  LANES*DATA_WIDTH  packed signed results.
REQ-014 Ports C, N, V, Z  output  LANES each  per-lane carry, negative, overflow, zero flags.

Function
REQ-015 Request accepted on a clk edge where in_valid && in_ready; A, B, opcode, sat captured at that edge.
REQ-016 in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-017 FSM states IDLE, MUL, DONE; IDLE->DONE on accepted add/sub/pass; IDLE->MUL on accepted mul; MUL->DONE after DATA_WIDTH iteration cycles; DONE->IDLE same edge result loads.
REQ-018 Latency: add/sub/pass out_valid rises 1 cycle after acceptance; mul out_valid rises DATA_WIDTH+1 cycles after acceptance.
REQ-019 Mul uses an iterative shift-add per lane on operand magnitudes, 1 bit per cycle, sign applied at completion; all lanes iterate in lockstep.
REQ-020 out_valid, Out, flags hold stable while out_valid && !out_ready; out_valid clears on out_valid && out_ready unless a new result loads the same edge.
REQ-021 Add: exact = A+B (DATA_WIDTH+1 bits); C = unsigned carry out; V = operands same sign and exact sign differs.
REQ-022 Sub: computed as A + ~B + 1; C = carry out (1 = no borrow); V = operands differ in sign and result sign differs from A.
REQ-023 Mul: exact 2*DATA_WIDTH-bit signed product; V = product outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; C = 0.
REQ-024 Pass: Out = A; C = V = 0.
REQ-025 Overflow with sat=1: Out = max positive (0111..1) if exact result positive, min negative (1000..0) if negative; with sat=0: Out = low DATA_WIDTH bits of exact result.
REQ-026 N = MSB of final Out; Z = (final Out == 0); both computed after saturation/wrap.
REQ-027 Lanes fully independent; no carry or flag interaction across lanes.
REQ-028 in_valid while in_ready=0 is ignored; requester holds it.

Reset
REQ-029 rst high: state=IDLE, out_valid=0, Out=0, C=N=V=Z=0, multiplier accumulators cleared, effective immediately (asynchronous).
REQ-030 rst during MUL aborts the operation; no result is produced after rst deasserts; in_ready=1 on the first cycle after deassertion.

Verification (DATA_WIDTH=8, LANES=2)
REQ-031 Add sat=1: lane0 0x7F+0x01, lane1 0x01+0xFF -> lane0 Out=0x7F V=1 N=0; lane1 Out=0x00 Z=1 C=1 V=0; out_valid 1 cycle after accept.
REQ-032 Sub sat=1: lane0 0x80-0x0A, lane1 0x0A-0x80 -> lane0 Out=0x80 V=1 N=1; lane1 Out=0x7F V=1 N=0; sat=0 same inputs -> lane0 0x76, lane1 0x8A, V=1.
REQ-033 Mul sat=1: lane0 0xFB*0xFE, lane1 0xC0*0x0A -> lane0 Out=0x0A V=0; lane1 Out=0x80 V=1 N=1; out_valid exactly 9 cycles after accept, in_ready=0 throughout.
REQ-034 Backpressure: out_ready=0 for 5 cycles after an add result -> Out/flags stable, in_ready=0; out_ready=1 with new in_valid same cycle -> next result loads back-to-back.
REQ-035 Reset mid-mul: assert rst 4 cycles into mul -> out_valid=0 and all outputs 0 immediately; no out_valid after release; next add 0x01+0x01 returns 0x02 in 1 cycle.
